// File: rtl/ami_port_arbiter_if.sv
// Bus bundle for ami_port_arbiter: two requester ports, the shared memory port,
// and status outputs. The arbiter takes the slave view; the environment takes the master view.
interface ami_port_arbiter_if #(
    parameter int unsigned REQ_W   = 642,
    parameter int unsigned RESP_W  = 577,
    parameter int unsigned MAX_OUT = 8,
    parameter int unsigned CNT_W   = 32
);
    localparam int unsigned OUT_W = $clog2(MAX_OUT) + 1;

    logic [REQ_W-1:0]  req0;
    logic [REQ_W-1:0]  req1;
    logic              req0_grant;
    logic              req1_grant;
    logic [RESP_W-1:0] resp0;
    logic [RESP_W-1:0] resp1;
    logic              resp0_grant;
    logic              resp1_grant;
    logic [REQ_W-1:0]  mem_req;
    logic              mem_req_grant;
    logic [RESP_W-1:0] mem_resp;
    logic              mem_resp_grant;
    logic [OUT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  rd_issued;
    logic [CNT_W-1:0]  wr_issued;
    logic              orphan_err;

    modport slave (
        input  req0, req1, resp0_grant, resp1_grant, mem_req_grant, mem_resp,
        output req0_grant, req1_grant, resp0, resp1, mem_req, mem_resp_grant,
               outstanding, rd_issued, wr_issued, orphan_err
    );

    modport master (
        output req0, req1, resp0_grant, resp1_grant, mem_req_grant, mem_resp,
        input  req0_grant, req1_grant, resp0, resp1, mem_req, mem_resp_grant,
               outstanding, rd_issued, wr_issued, orphan_err
    );
endinterface

// File: rtl/ami_port_arbiter.sv
// Round-robin arbiter sharing one AMI memory port between the read (0) and write (1)
// requesters. Winning request is registered in a one-entry output stage; an in-order tag
// FIFO steers each memory response back to the requester that issued it.
// Request valid is the MSB of the request bus; response valid is bit 0.
module ami_port_arbiter #(
    parameter int unsigned REQ_W   = 642,
    parameter int unsigned RESP_W  = 577,
    parameter int unsigned MAX_OUT = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    ami_port_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(MAX_OUT);
    localparam int unsigned OW = AW + 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(MAX_OUT);

    // Output stage
    logic [REQ_W-1:0] r_obuf;
    logic             r_ofull;
    logic             r_last;

    // Tag FIFO: one bit per entry holds the issuing port
    logic [MAX_OUT-1:0] r_tag;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [OW-1:0]      r_count;

    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic             r_orphan;

    logic              w_empty;
    logic              w_head;
    logic              w_resp_valid;
    logic [RESP_W-1:0] w_resp0;
    logic [RESP_W-1:0] w_resp1;
    logic              w_mem_resp_grant;
    logic              w_pop;
    logic              w_free;
    logic              w_slot;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_win0;
    logic              w_win1;
    logic              w_push;

    assign w_empty      = (r_count == '0);
    assign w_head       = r_tag[r_rptr];
    assign w_resp_valid = bus.mem_resp[0];

    // Route the memory response to the head-tag owner; drop it when nothing is outstanding
    always_comb begin
        w_resp0          = '0;
        w_resp1          = '0;
        w_mem_resp_grant = 1'b0;
        if (!rst) begin
            if (w_empty) begin
                w_mem_resp_grant = w_resp_valid;
            end else if (w_head) begin
                w_resp1          = bus.mem_resp;
                w_mem_resp_grant = bus.resp1_grant;
            end else begin
                w_resp0          = bus.mem_resp;
                w_mem_resp_grant = bus.resp0_grant;
            end
        end
    end

    assign w_pop = w_resp_valid & w_mem_resp_grant & ~w_empty;

    // A same-cycle pop frees a FIFO slot, so a full FIFO can still accept a grant
    assign w_free  = ~r_ofull | bus.mem_req_grant;
    assign w_slot  = (r_count != FULL_CNT) | w_pop;
    assign w_elig0 = ~rst & w_free & w_slot & bus.req0[REQ_W-1];
    assign w_elig1 = ~rst & w_free & w_slot & bus.req1[REQ_W-1];
    // On a tie the port that did not win last time goes first
    assign w_win0  = w_elig0 & (~w_elig1 | r_last);
    assign w_win1  = w_elig1 & (~w_elig0 | ~r_last);
    assign w_push  = w_win0 | w_win1;

    // Output stage: load the winner, drain on memory accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_obuf  <= '0;
            r_ofull <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_push) begin
            r_obuf  <= w_win1 ? bus.req1 : bus.req0;
            r_ofull <= 1'b1;
            r_last  <= w_win1;
        end else if (bus.mem_req_grant) begin
            r_ofull <= 1'b0;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_win1;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + OW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - OW'(1);
            end
        end
    end

    // Per-port issue counters (wrap naturally) and sticky orphan-response flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_win0) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
            if (w_win1) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_resp_valid && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign bus.req0_grant     = w_win0;
    assign bus.req1_grant     = w_win1;
    assign bus.resp0          = w_resp0;
    assign bus.resp1          = w_resp1;
    assign bus.mem_resp_grant = w_mem_resp_grant;
    assign bus.mem_req        = r_ofull ? r_obuf : '0;
    assign bus.outstanding    = r_count;
    assign bus.rd_issued      = r_rd_cnt;
    assign bus.wr_issued      = r_wr_cnt;
    assign bus.orphan_err     = r_orphan;
endmodule

// File: doc/ami_port_arbiter.md
# ami_port_arbiter

Shares one downstream AMI memory port between the accelerator's read-request port (requester 0, `mem_req0`/`mem_resp0`) and write-request port (requester 1, `mem_req1`/`mem_resp1`). It applies round-robin arbitration, registers the winning request in a one-entry output stage, and tracks outstanding requests in an in-order tag FIFO so each downstream response returns to the requester that issued it. It sits between `dnnweaver_ami_top` and the memory model or driver. The driver then sees a single request/response pair and per-port issue counters.

## Interface
- `REQ_W`, default `AMI_REQUEST_BUS_WIDTH`: request bus width.
- `RESP_W`, default `AMI_RESPONSE_BUS_WIDTH`: response bus width. Valid is bit 0.
- `MAX_OUT`, default 8: tag-FIFO depth, which is the maximum number of outstanding requests. Power of two, ≥2.
- `CNT_W`, default 32: width of the issue counters.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req0`, `req1` in `REQ_W`: requester buses. Valid is field `AMIRequest_valid`.
- `req0_grant`, `req1_grant` out 1: a request was accepted this cycle.
- `resp0`, `resp1` out `RESP_W`: routed responses.
- `resp0_grant`, `resp1_grant` in 1: requester consumed its response.
- `mem_req` out `REQ_W`: registered request to memory.
- `mem_req_grant` in 1: memory accepted `mem_req`.
- `mem_resp` in `RESP_W`: memory response.
- `mem_resp_grant` out 1: response consumed.
- `outstanding` out `log2(MAX_OUT)+1`: FIFO occupancy.
- `rd_issued`, `wr_issued` out `CNT_W`: requests accepted from port 0 and port 1.
- `orphan_err` out 1: sticky; a response arrived with no outstanding tag.

## Operation
Output stage:
- Holds one entry in `obuf`, with flag `ofull`.
- `mem_req` = `obuf` when `ofull`, else all zeros. The valid field therefore mirrors `ofull`.
- The stage can accept a new request when `free = !ofull | mem_req_grant`.

Arbitration:
- Eligible port set: `free`, FIFO not full (counting a same-cycle pop), and the port's valid bit set.
- One eligible port: that port wins.
- Both eligible: the port that did not win last wins.
- `last` resets to 1, so port 0 wins the first tie.
- The winner's grant is combinational in the same cycle. At most one grant is high.

On a grant:
- `obuf` <= winner's bus, `ofull` <= 1.
- Winner ID is pushed to the tag FIFO.
- `last` <= winner ID.
- The matching issue counter increments, wrapping modulo 2^`CNT_W`.

On `mem_req_grant` with no new winner: `ofull` <= 0.

Response routing:
- Head tag 0 → `resp0` = `mem_resp`, `resp1` = 0, `mem_resp_grant` = `resp0_grant`.
- Head tag 1 → the mirror of the above.
- Pop the FIFO when `mem_resp` valid and `mem_resp_grant` are both high.
- `mem_resp` valid with the FIFO empty: `mem_resp_grant` = 1 (the response is dropped), both `resp` outputs = 0, `orphan_err` <= 1.

Simultaneous events:
- A push and a pop in the same cycle leave `outstanding` unchanged.
- A pop in the same cycle frees a slot for a grant when the FIFO is full.

`outstanding` = push count − pop count, range 0..`MAX_OUT`.

The block does no content checking of requests. The `isWrite` bit passes through unchanged.

## Timing
- Reset: `ofull`=0, `mem_req`=0, FIFO empty, `outstanding`=0, counters=0, `last`=1, `orphan_err`=0, both grants 0, both resp buses 0, `mem_resp_grant`=0.
- Reset asserted mid-operation: all in-flight state and tags are discarded immediately. Late responses after reset release set `orphan_err`.
- Request latency: a request granted in cycle N appears on `mem_req` in cycle N+1.
- Back-to-back throughput: one request per cycle while memory grants continuously.
- Response path: combinational, zero cycles.
- A requester holds its bus until granted. The arbiter never drops a request it has not granted.
- FIFO full with no pop this cycle: both grants are 0. `ofull` may still drain.

## Test plan
- Reset then idle: all outputs zero.
- Single read: `req0` valid, addr 0x40 → `req0_grant` in cycle N; `mem_req` addr 0x40 in N+1. Respond with data 0xAB → `resp0` valid, `resp1`=0. Then `outstanding` 1→0, `rd_issued`=1.
- Contention: both ports valid continuously with `mem_req_grant`=1 → grants alternate 0,1,0,1. After 10 cycles `rd_issued`=5 and `wr_issued`=5.
- Full stall: memory never responds, `MAX_OUT`=8 → exactly 8 grants, then both grants stay 0. One response frees a slot → a grant in the same cycle.
- Ordering: issue R,W,R, then return three responses → routed to ports 0,1,0 in order. A response with `resp1_grant`=0 holds until it is consumed.
- Orphan response and async reset: `mem_resp` valid with the FIFO empty → `mem_resp_grant`=1 and `orphan_err`=1 (sticky). Assert `rst` mid-burst → `ofull`, `outstanding`, and the counters clear without waiting for a clock edge.
